list_mac_sequencer: RTL and testbench

//  Sequences the 4-bit digit lookup unit (comp1/comp2/i/j -> 17-bit shifted partial, 1-cycle registered).

---
 rtl/list_pkg.sv | 17 +
 rtl/list_valid_pipe.sv | 31 +++
 rtl/list_mac_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_list_mac_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/list_pkg.sv
// Shared types and widths for the digit-pair MAC sequencer.
package list_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned LUT_DATA_W = 17;
  // Largest operand the 3-bit digit indices can address.
  localparam int unsigned MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } seq_state_e;

endpackage

// File: rtl/list_valid_pipe.sv
// Valid-bit shift register that tracks which lookup returns carry a real partial.
module list_valid_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic vld_i,
  output logic tail_o,
  output logic busy_o
);

  logic [DEPTH-1:0] pipe_q, pipe_d;

  // Shift one slot per cycle; a new bit enters at index 0.
  always_comb begin
    pipe_d = (pipe_q << 1) | DEPTH'(vld_i);
  end

  // Async clear drops any in-flight partials on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tail_o = pipe_q[DEPTH-1];
  assign busy_o = |pipe_q;

endmodule

// File: rtl/list_mac_sequencer.sv
// Latches two multi-digit operands, issues every digit pair to the lookup unit
// (i outer, j inner) and accumulates the returned shifted partials.
// Optional LIST_SEQ_PERF_EN adds a 16-bit saturating accept-to-result cycle count.
module list_mac_sequencer
  import list_pkg::*;
#(
  parameter int unsigned N_DIGITS = 2,
  parameter int unsigned LUT_LAT  = 1,
  parameter int unsigned ACC_W    = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DIGIT_W*N_DIGITS-1:0]  op_a,
  input  logic [DIGIT_W*N_DIGITS-1:0]  op_b,
  output logic [DIGIT_W-1:0]           comp1,
  output logic [DIGIT_W-1:0]           comp2,
  output logic [IDX_W-1:0]             i,
  output logic [IDX_W-1:0]             j,
  input  logic [LUT_DATA_W-1:0]        lut_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             result,
  output logic                         busy
`ifdef LIST_SEQ_PERF_EN
  ,
  output logic [15:0]                  cycles
`endif
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_DIGITS - 1);
  localparam int unsigned      OpW     = N_DIGITS * DIGIT_W;
  localparam int unsigned      PackW   = MAX_DIGITS * DIGIT_W;

  seq_state_e                        state_q, state_d;
  logic [OpW-1:0]                    op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ACC_W-1:0]                  acc_q, acc_d, result_q, result_d;
  logic [DIGIT_W-1:0]                comp1_q, comp1_d, comp2_q, comp2_d;
  logic [IDX_W-1:0]                  i_q, i_d, j_q, j_d;
  logic                              issue_vld_q, issue_vld_d;
  logic                              in_ready_q, in_ready_d;
  logic                              out_valid_q, out_valid_d;
  logic                              busy_q, busy_d;
  logic                              pipe_tail, pipe_busy, accept, finish;
  // Zero-padded digit views so a 3-bit index never runs off the end.
  logic [MAX_DIGITS-1:0][DIGIT_W-1:0] a_in, b_in, a_lat, b_lat;

  assign a_in   = PackW'(op_a);
  assign b_in   = PackW'(op_b);
  assign a_lat  = PackW'(op_a_q);
  assign b_lat  = PackW'(op_b_q);
  assign accept = (state_q == StIdle) && in_valid;
  assign finish = (state_q == StDrain) && !pipe_busy;

  // issue_vld_q marks cycles where comp/i/j present a freshly issued pair.
  list_valid_pipe #(
    .DEPTH (LUT_LAT)
  ) u_valid_pipe (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (issue_vld_q),
    .tail_o (pipe_tail),
    .busy_o (pipe_busy)
  );

  // Next-state: pair walk, accumulation and handshake outputs.
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    comp1_d     = comp1_q;
    comp2_d     = comp2_q;
    i_d         = i_q;
    j_d         = j_q;
    issue_vld_d = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    if (pipe_tail) begin
      acc_d = acc_q + ACC_W'(lut_data);
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_a_d      = op_a;
          op_b_d      = op_b;
          acc_d       = '0;
          i_d         = '0;
          j_d         = '0;
          comp1_d     = a_in[0];
          comp2_d     = b_in[0];
          issue_vld_d = 1'b1;
          in_ready_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (i_q == LastIdx && j_q == LastIdx) begin
          state_d = StDrain;
        end else begin
          if (j_q == LastIdx) begin
            i_d = i_q + 1'b1;
            j_d = '0;
          end else begin
            j_d = j_q + 1'b1;
          end
          comp1_d     = a_lat[i_d];
          comp2_d     = b_lat[j_d];
          issue_vld_d = 1'b1;
        end
      end
      StDrain: begin
        if (!pipe_busy) begin
          result_d    = acc_q;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      op_a_q      <= '0;
      op_b_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      comp1_q     <= '0;
      comp2_q     <= '0;
      i_q         <= '0;
      j_q         <= '0;
      issue_vld_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      comp1_q     <= comp1_d;
      comp2_q     <= comp2_d;
      i_q         <= i_d;
      j_q         <= j_d;
      issue_vld_q <= issue_vld_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign comp1     = comp1_q;
  assign comp2     = comp2_q;
  assign i         = i_q;
  assign j         = j_q;

`ifdef LIST_SEQ_PERF_EN
  logic [15:0] run_cnt_q, run_cnt_d, cycles_q, cycles_d;

  // Running count starts at 1 on the accept edge; snapshot it when the result turns valid.
  always_comb begin
    run_cnt_d = run_cnt_q;
    cycles_d  = cycles_q;
    if (accept) begin
      run_cnt_d = 16'd1;
    end else if ((state_q == StIssue || state_q == StDrain) && run_cnt_q != 16'hFFFF) begin
      run_cnt_d = run_cnt_q + 16'd1;
    end
    if (finish) begin
      cycles_d = run_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt_q <= '0;
      cycles_q  <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
      cycles_q  <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_list_mac_sequencer.sv
// Self-checking bench for list_mac_sequencer (N_DIGITS=2, LUT_LAT=1, ACC_W=20).
// Drives directed and random operand pairs; a timeline model predicts every output each cycle.
module tb_list_mac_sequencer;

  localparam int unsigned N       = 2;
  localparam int unsigned LAT     = 1;
  localparam int unsigned AW      = 20;
  localparam int unsigned LATENCY = N * N + LAT + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]    op_a, op_b;
  logic [3:0]    comp1, comp2;
  logic [2:0]    i, j;
  logic [16:0]   lut_data = '0;
  logic [AW-1:0] result;
`ifdef LIST_SEQ_PERF_EN
  logic [15:0]   cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  list_mac_sequencer #(
    .N_DIGITS (N),
    .LUT_LAT  (LAT),
    .ACC_W    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .comp1     (comp1),
    .comp2     (comp2),
    .i         (i),
    .j         (j),
    .lut_data  (lut_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
`ifdef LIST_SEQ_PERF_EN
    ,
    .cycles    (cycles)
`endif
  );

  // Registered lookup unit stand-in: (comp1*comp2) << (i+j), truncated to 17 bits.
  always @(posedge clk) lut_data <= 17'((17'(comp1) * 17'(comp2)) << (i + j));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Sum of every digit pair product shifted by (x+y), each term cut to 17 bits.
  function automatic logic [AW-1:0] mac(input logic [7:0] a, input logic [7:0] b);
    logic [AW-1:0] s;
    logic [16:0]   p;
    s = '0;
    for (int x = 0; x < N; x++) begin
      for (int y = 0; y < N; y++) begin
        p = 17'((17'(a[4*x +: 4]) * 17'(b[4*y +: 4])) << (x + y));
        s = s + AW'(p);
      end
    end
    return s;
  endfunction

  // Timeline model: m_cnt = clock edges since accept.
  bit            m_active = 1'b0;
  bit            m_fresh  = 1'b1;
  int            m_cnt    = 0;
  logic [7:0]    m_a = '0, m_b = '0;
  logic [AW-1:0] m_sum = '0, m_res = '0;
  logic [2:0]    m_i = '0, m_j = '0;
  logic [3:0]    m_c1 = '0, m_c2 = '0;
  logic [15:0]   m_cycles = '0;

  initial begin
    int  k;
    bit  ov_exp;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_active = 1'b0; m_fresh = 1'b1; m_cnt = 0; m_res = '0;
        m_i = '0; m_j = '0; m_c1 = '0; m_c2 = '0; m_cycles = '0;
      end else begin
        if (!m_active) begin
          if (in_valid) begin
            m_active = 1'b1; m_cnt = 0; m_fresh = 1'b0;
            m_a = op_a; m_b = op_b; m_sum = mac(op_a, op_b);
          end
        end else if (m_cnt >= LATENCY && out_ready) begin
          m_active = 1'b0;
        end else begin
          m_cnt++;
          if (m_cnt == LATENCY) begin
            m_res    = m_sum;
            m_cycles = 16'(LATENCY);
          end
        end
        if (m_active) begin
          k    = (m_cnt < N * N) ? m_cnt : N * N - 1;
          m_i  = 3'(k / N);
          m_j  = 3'(k % N);
          m_c1 = m_a[4*m_i +: 4];
          m_c2 = m_b[4*m_j +: 4];
        end
      end
      #1;
      ov_exp = m_active && (m_cnt >= LATENCY);
      chk("in_ready", 32'(in_ready), 32'(!m_active));
      chk("busy", 32'(busy), 32'(m_active));
      chk("out_valid", 32'(out_valid), 32'(ov_exp));
      if (ov_exp || m_fresh) chk("result", 32'(result), 32'(m_res));
      chk("i", 32'(i), 32'(m_i));
      chk("j", 32'(j), 32'(m_j));
      chk("comp1", 32'(comp1), 32'(m_c1));
      chk("comp2", 32'(comp2), 32'(m_c2));
`ifdef LIST_SEQ_PERF_EN
      chk("cycles", 32'(cycles), 32'(m_cycles));
`endif
    end
  end

  // Called at a negedge with the DUT idle; returns the result and accept-to-valid latency.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                       output logic [AW-1:0] res, output int lat);
    in_valid = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    in_valid = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic wait_ov(input string nm);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(n < 100), 32'd1);
  endtask

  initial begin
    logic [AW-1:0] res;
    int            lat;
    logic [7:0]    ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Zero A digits give zero partials regardless of B.
    do_op(8'h00, 8'hFF, 0, res, lat);
    chk("c1_result", 32'(res), 32'd0);
    chk("c1_latency", 32'(lat), 32'd6);

    // A=(1,2), B=(3,1): 3<<0 + 1<<1 + 6<<1 + 2<<2 = 3+2+12+8 = 25.
    do_op(8'h21, 8'h13, 0, res, lat);
    chk("c2_result", 32'(res), 32'd25);
    chk("c2_latency", 32'(lat), 32'd6);
`ifdef LIST_SEQ_PERF_EN
    chk("c6_cycles", 32'(cycles), 32'd6);
`endif

    // 225 + 450 + 450 + 900, held 5 cycles before the consumer accepts.
    do_op(8'hFF, 8'hFF, 5, res, lat);
    chk("c3_result", 32'(res), 32'd2025);
    chk("c3_hold_result", 32'(result), 32'd2025);

    // in_valid held across an op: second accept lands right after the out handshake.
    in_valid = 1'b1; op_a = 8'h21; op_b = 8'h13;
    wait_ov("c4_wait1");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("c4_idle_after_hs", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("c4_reaccept", 32'(busy), 32'd1);
    in_valid = 1'b0;
    wait_ov("c4_wait2");
    chk("c4_result", 32'(result), 32'd25);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset pulse during the third issue cycle.
    in_valid = 1'b1; op_a = 8'hFF; op_b = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("c5_in_ready", 32'(in_ready), 32'd1);
    chk("c5_out_valid", 32'(out_valid), 32'd0);
    chk("c5_result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h21, 8'h13, 1, res, lat);
    chk("c5_next_result", 32'(res), 32'd25);

    // Random operands, consumer delays and idle gaps.
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(ra, rb, int'($urandom_range(0, 3)), res, lat);
      chk("rnd_result", 32'(res), 32'(mac(ra, rb)));
      chk("rnd_latency", 32'(lat), 32'(LATENCY));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
